// File: rtl/ph_alarm_controller.sv
// Alarm controller for blood-pH analyzer flags: consecutive-sample filtering,
// a NORMAL/WARN/ALARM/HOLD state machine and a saturating alarm-event counter.
module ph_alarm_controller #(
    parameter int unsigned WARN_COUNT  = 3,
    parameter int unsigned ALARM_COUNT = 2,
    parameter int unsigned CLEAR_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sampleValid,
    input  logic       abnormalityP,
    input  logic       abnormalityQ,
    input  logic       alarmAck,
    output logic       warning,
    output logic       alarm,
    output logic       buzzer,
    output logic [7:0] alarmEvents,
    output logic [1:0] state
);

    localparam int unsigned PW = $clog2(ALARM_COUNT + 1);
    localparam int unsigned QW = $clog2(WARN_COUNT + 1);
    localparam int unsigned OW = $clog2(CLEAR_COUNT + 1);

    localparam logic [PW-1:0] P_MAX  = PW'(ALARM_COUNT);
    localparam logic [QW-1:0] Q_MAX  = QW'(WARN_COUNT);
    localparam logic [OW-1:0] OK_MAX = OW'(CLEAR_COUNT);

    typedef enum logic [1:0] {
        StNormal = 2'd0,
        StWarn   = 2'd1,
        StAlarm  = 2'd2,
        StHold   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] p_run_q, p_run_d;
    logic [QW-1:0] q_run_q, q_run_d;
    logic [OW-1:0] ok_run_q, ok_run_d;
    logic [7:0]    events_q, events_d;
    logic          warning_q, alarm_q, buzzer_q;
    logic          q_eff;

    always_comb begin
        // A critical flag always implies out-of-band.
        q_eff    = abnormalityQ | abnormalityP;
        p_run_d  = p_run_q;
        q_run_d  = q_run_q;
        ok_run_d = ok_run_q;
        state_d  = state_q;
        events_d = events_q;

        if (sampleValid) begin
            p_run_d  = abnormalityP ? ((p_run_q == P_MAX) ? p_run_q : p_run_q + 1'b1) : '0;
            q_run_d  = q_eff ? ((q_run_q == Q_MAX) ? q_run_q : q_run_q + 1'b1) : '0;
            ok_run_d = !q_eff ? ((ok_run_q == OK_MAX) ? ok_run_q : ok_run_q + 1'b1) : '0;
        end

        // Run thresholds are compared against the count including this sample.
        if (sampleValid && state_q != StAlarm && p_run_d == P_MAX) begin
            state_d = StAlarm;
            if (events_q != 8'hFF) begin
                events_d = events_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                StNormal: if (sampleValid && q_run_d == Q_MAX) state_d = StWarn;
                StWarn:   if (sampleValid && ok_run_d == OK_MAX) state_d = StNormal;
                StAlarm:  if (sampleValid && ok_run_d == OK_MAX) state_d = StHold;
                StHold: begin
                    // Acknowledge is honoured with or without a sample.
                    if (alarmAck) begin
                        state_d  = StNormal;
                        p_run_d  = '0;
                        q_run_d  = '0;
                        ok_run_d = '0;
                    end
                end
                default: state_d = StNormal;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StNormal;
            p_run_q   <= '0;
            q_run_q   <= '0;
            ok_run_q  <= '0;
            events_q  <= '0;
            warning_q <= 1'b0;
            alarm_q   <= 1'b0;
            buzzer_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_run_q   <= p_run_d;
            q_run_q   <= q_run_d;
            ok_run_q  <= ok_run_d;
            events_q  <= events_d;
            warning_q <= (state_d == StWarn);
            alarm_q   <= (state_d == StAlarm) || (state_d == StHold);
            buzzer_q  <= (state_d == StAlarm);
        end
    end

    assign warning     = warning_q;
    assign alarm       = alarm_q;
    assign buzzer      = buzzer_q;
    assign alarmEvents = events_q;
    assign state       = state_q;

endmodule

// File: tb/tb_ph_alarm_controller.sv
// Self-checking bench for ph_alarm_controller: directed scenarios plus random
// stimulus, all compared against a behavioural model of the alarm rules.
module tb_ph_alarm_controller;

    localparam int AC = 2;
    localparam int WC = 3;
    localparam int CC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sampleValid = 1'b0;
    logic       abnormalityP = 1'b0;
    logic       abnormalityQ = 1'b0;
    logic       alarmAck = 1'b0;
    logic       warning, alarm, buzzer;
    logic [7:0] alarmEvents;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_st = 0;
    int m_ev = 0;
    int m_p = 0;
    int m_q = 0;
    int m_ok = 0;

    ph_alarm_controller #(
        .WARN_COUNT (WC),
        .ALARM_COUNT(AC),
        .CLEAR_COUNT(CC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sampleValid (sampleValid),
        .abnormalityP(abnormalityP),
        .abnormalityQ(abnormalityQ),
        .alarmAck    (alarmAck),
        .warning     (warning),
        .alarm       (alarm),
        .buzzer      (buzzer),
        .alarmEvents (alarmEvents),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model of the alarm rules; states: 0 normal, 1 warn, 2 alarm, 3 hold.
    task automatic model(input bit v, input bit p, input bit q, input bit ack, input bit r);
        int np, nq, nok;
        if (r) begin
            m_st = 0; m_ev = 0; m_p = 0; m_q = 0; m_ok = 0;
            return;
        end
        np = m_p; nq = m_q; nok = m_ok;
        if (v) begin
            np  = p ? min2(m_p + 1, AC) : 0;
            nq  = (p | q) ? min2(m_q + 1, WC) : 0;
            nok = !(p | q) ? min2(m_ok + 1, CC) : 0;
        end
        m_p = np; m_q = nq; m_ok = nok;
        if (v && m_st != 2 && np == AC) begin
            m_st = 2;
            m_ev = min2(m_ev + 1, 255);
        end else if (v && m_st == 0 && nq == WC) begin
            m_st = 1;
        end else if (v && m_st == 1 && nok == CC) begin
            m_st = 0;
        end else if (v && m_st == 2 && nok == CC) begin
            m_st = 3;
        end else if (m_st == 3 && ack) begin
            m_st = 0; m_p = 0; m_q = 0; m_ok = 0;
        end
    endtask

    task automatic step(input bit v, input bit p, input bit q, input bit ack, input bit r);
        sampleValid  = v;
        abnormalityP = p;
        abnormalityQ = q;
        alarmAck     = ack;
        rst          = r;
        @(posedge clk);
        model(v, p, q, ack, r);
        #1;
        check("state", 32'(state), 32'(m_st));
        check("warning", 32'(warning), 32'(m_st == 1));
        check("alarm", 32'(alarm), 32'(m_st >= 2));
        check("buzzer", 32'(buzzer), 32'(m_st == 2));
        check("alarmEvents", 32'(alarmEvents), 32'(m_ev));
    endtask

    task automatic smp(input bit p, input bit q);
        step(1'b1, p, q, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit p, input bit q, input bit ack);
        step(1'b0, p, q, ack, 1'b0);
    endtask

    task automatic full_alarm_cycle();
        smp(1, 0); smp(1, 0);
        for (int i = 0; i < CC; i++) smp(0, 0);
        idle(0, 0, 1);
    endtask

    initial begin
        // Reset with all flags active
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_events", 32'(alarmEvents), 32'd0);

        // Warning path with invalid cycles (carrying flags) interleaved
        smp(0, 1); idle(0, 0, 0); smp(0, 1); idle(1, 1, 0); smp(0, 1);
        check("warn_state", 32'(state), 32'd1);
        check("warn_out", 32'(warning), 32'd1);
        for (int i = 0; i < CC; i++) begin
            smp(0, 0);
            idle(0, 1, 0);
        end
        check("warn_clear", 32'(state), 32'd0);

        // P run broken by a Q-only sample
        smp(1, 0); smp(0, 1); smp(1, 0);
        check("pbreak_no_alarm", 32'(buzzer), 32'd0);
        for (int i = 0; i < CC; i++) smp(0, 0);

        // Alarm path
        smp(1, 0); smp(1, 0);
        check("alarm_state", 32'(state), 32'd2);
        check("alarm_events1", 32'(alarmEvents), 32'd1);
        smp(1, 0);
        check("alarm_no_reinc", 32'(alarmEvents), 32'd1);
        idle(0, 0, 1); smp(0, 0);
        check("ack_ignored", 32'(state), 32'd2);
        for (int i = 0; i < CC - 1; i++) smp(0, 0);
        check("hold_state", 32'(state), 32'd3);
        check("hold_buzzer", 32'(buzzer), 32'd0);
        check("hold_alarm", 32'(alarm), 32'd1);
        idle(0, 0, 0);
        check("hold_stays", 32'(state), 32'd3);
        idle(0, 0, 1);
        check("ack_to_normal", 32'(state), 32'd0);

        // Re-trigger on the same edge as ack beats the ack
        full_alarm_cycle();
        smp(1, 0); smp(1, 0);
        for (int i = 0; i < CC; i++) smp(0, 0);
        smp(1, 0);
        step(1, 1, 0, 1, 0);
        check("retrigger_state", 32'(state), 32'd2);
        check("retrigger_events", 32'(alarmEvents), 32'd4);

        // Reset while in ALARM with five events recorded
        for (int i = 0; i < CC; i++) smp(0, 0);
        idle(0, 0, 1);
        smp(1, 0); smp(1, 0);
        check("pre_reset_events", 32'(alarmEvents), 32'd5);
        step(1, 1, 1, 0, 1);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_events", 32'(alarmEvents), 32'd0);
        smp(1, 0);
        check("midrst_single_p", 32'(state), 32'd0);
        smp(0, 0);

        // Saturation of the event counter
        for (int i = 0; i < 256; i++) full_alarm_cycle();
        check("sat_events", 32'(alarmEvents), 32'd255);
        smp(1, 0); smp(1, 0);
        check("sat_no_wrap", 32'(alarmEvents), 32'd255);
        step(0, 0, 0, 0, 1);

        // Random stimulus, occasionally resetting
        for (int i = 0; i < 1500; i++) begin
            bit v, p, q, a, r;
            v = ($urandom_range(3) != 0);
            p = ($urandom_range(2) == 0);
            q = ($urandom_range(1) == 0);
            a = ($urandom_range(5) == 0);
            r = ($urandom_range(199) == 0);
            step(v, p, q, a, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
